seq_match_logger: RTL and testbench

//   Event logger directly downstream of the 3-bit sequence detector. Consumes its
//   one-cycle sequence_found pulse and timestamps each detection against a free-running

---
 rtl/seq_match_logger.sv | 107 ++++++++++
 tb/tb_seq_match_logger.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_match_logger.sv
// seq_match_logger
//   Timestamps each sequence_found pulse against a free-running cycle counter and
//   buffers the stamps in a small first-word-fall-through FIFO for a valid/ready
//   reader. Keeps a saturating count of every pulse seen, including dropped ones.
//   Sets a sticky overflow flag when a pulse arrives while the FIFO is full and
//   nothing is popped.
//
// Ports
//   clk             in   rising-edge clock
//   reset_n         in   async active-low reset
//   sequence_found  in   detector pulse, one event per cycle held high
//   rd_ready        in   reader accepts the head entry this cycle
//   rd_valid        out  FIFO holds at least one entry
//   rd_timestamp    out  head-entry timestamp (0 while empty)
//   fifo_level      out  entries currently held
//   match_count     out  total pulses seen, saturating
//   overflow        out  sticky: a pulse was dropped while the FIFO was full
//   clear_overflow  in   synchronous clear of overflow (a same-edge drop wins)
module seq_match_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sequence_found,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [TS_W-1:0]              rd_timestamp,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [CNT_W-1:0]             match_count,
  output logic                         overflow,
  input  logic                         clear_overflow
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic {EMPTY, NON_EMPTY} occ_t;

  occ_t              state_q, state_d;
  logic [TS_W-1:0]   ts_q;
  logic [TS_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              full, push, pop, drop;

  // Occupancy view: EMPTY / NON_EMPTY tracks the registered level, FULL is a flag.
  always_comb begin
    full    = 1'b0;
    pop     = 1'b0;
    push    = 1'b0;
    drop    = 1'b0;
    level_d = level_q;
    state_d = state_q;

    full = (level_q == FULL_LVL);
    pop  = (state_q == NON_EMPTY) && rd_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    push = sequence_found && (!full || pop);
    drop = sequence_found && full && !pop;

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    state_d = (level_d == '0) ? EMPTY : NON_EMPTY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      ts_q    <= ts_q + TS_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (sequence_found && (count_q != '1)) count_q <= count_q + CNT_W'(1);
      if (drop)                ovf_q <= 1'b1;
      else if (clear_overflow) ovf_q <= 1'b0;
    end
  end

  // Storage needs no reset: entries are only visible through the reset pointers/level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= ts_q;
  end

  assign rd_valid     = (state_q == NON_EMPTY);
  assign rd_timestamp = rd_valid ? mem[rd_ptr_q] : '0;
  assign fifo_level   = level_q;
  assign match_count  = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_seq_match_logger.sv
// tb_seq_match_logger
//   Drives two instances (default widths and TS_W=4/CNT_W=3) with identical
//   stimulus. Expected values come from one queue-based model that records the
//   absolute cycle number of each stored event; each instance's expectation is
//   that number reduced to its own width.
module tb_seq_match_logger;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sf = 1'b0;
  logic        rr = 1'b0;
  logic        co = 1'b0;

  logic        a_valid, b_valid, a_ovf, b_ovf;
  logic [15:0] a_ts;
  logic [3:0]  b_ts;
  logic [2:0]  a_lvl, b_lvl;
  logic [7:0]  a_cnt;
  logic [2:0]  b_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  int unsigned cyc = 0;
  int unsigned q[$];
  int unsigned npulse = 0;
  bit          m_ovf = 1'b0;

  always #5 clk = ~clk;

  seq_match_logger #(.TS_W(16), .DEPTH(DEPTH), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .sequence_found(sf), .rd_ready(rr),
    .rd_valid(a_valid), .rd_timestamp(a_ts), .fifo_level(a_lvl),
    .match_count(a_cnt), .overflow(a_ovf), .clear_overflow(co)
  );

  seq_match_logger #(.TS_W(4), .DEPTH(DEPTH), .CNT_W(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .sequence_found(sf), .rd_ready(rr),
    .rd_valid(b_valid), .rd_timestamp(b_ts), .fifo_level(b_lvl),
    .match_count(b_cnt), .overflow(b_ovf), .clear_overflow(co)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cyc    = 0;
    npulse = 0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the pre-edge inputs.
  task automatic model_edge(input bit s, input bit r, input bit c);
    bit popped;
    bit dropped;
    popped  = (q.size() != 0) && r;
    dropped = 1'b0;
    if (popped) void'(q.pop_front());
    if (s) begin
      npulse++;
      if (q.size() < DEPTH) q.push_back(cyc);
      else dropped = 1'b1;
    end
    if (dropped) m_ovf = 1'b1;
    else if (c)  m_ovf = 1'b0;
    cyc++;
  endtask

  task automatic check_all();
    int unsigned exp_a_cnt, exp_b_cnt;
    exp_a_cnt = (npulse > 255) ? 255 : npulse;
    exp_b_cnt = (npulse > 7) ? 7 : npulse;
    chk("a_valid", 32'(a_valid), 32'(q.size() != 0));
    chk("b_valid", 32'(b_valid), 32'(q.size() != 0));
    chk("a_level", 32'(a_lvl), 32'(q.size()));
    chk("b_level", 32'(b_lvl), 32'(q.size()));
    chk("a_count", 32'(a_cnt), exp_a_cnt);
    chk("b_count", 32'(b_cnt), exp_b_cnt);
    chk("a_ovf", 32'(a_ovf), 32'(m_ovf));
    chk("b_ovf", 32'(b_ovf), 32'(m_ovf));
    if (q.size() != 0) begin
      chk("a_ts", 32'(a_ts), q[0] % 65536);
      chk("b_ts", 32'(b_ts), q[0] % 16);
    end
  endtask

  task automatic tick(input bit s, input bit r, input bit c);
    sf = s;
    rr = r;
    co = c;
    @(posedge clk);
    model_edge(s, r, c);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sf = 1'b0;
    rr = 1'b0;
    co = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    chk("rst_a_ts", 32'(a_ts), 32'd0);
    chk("rst_b_ts", 32'(b_ts), 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    // 1: first capture after idle
    do_reset();
    for (int i = 0; i < 5; i++) tick(0, 0, 0);
    tick(1, 0, 0);
    chk("t1_ts5", 32'(a_ts), 32'd5);
    chk("t1_level", 32'(a_lvl), 32'd1);
    chk("t1_count", 32'(a_cnt), 32'd1);
    tick(0, 1, 0);

    // 2 and 4: fill, drop, set-wins-over-clear, then clear
    do_reset();
    for (int i = 0; i < 10; i++) tick(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0);
      tick(0, 0, 0);
    end
    tick(1, 0, 0);
    chk("t2_level", 32'(a_lvl), 32'd4);
    chk("t2_ovf", 32'(a_ovf), 32'd1);
    chk("t2_count", 32'(a_cnt), 32'd5);
    chk("t2_head", 32'(a_ts), 32'd10);
    tick(1, 0, 1);
    chk("t4_set_wins", 32'(a_ovf), 32'd1);
    tick(0, 0, 1);
    chk("t4_cleared", 32'(a_ovf), 32'd0);
    for (int i = 0; i < 4; i++) tick(0, 1, 0);

    // 3: push and pop on a full FIFO
    for (int i = 0; i < 4; i++) tick(1, 0, 0);
    tick(0, 0, 0);
    tick(1, 1, 0);
    chk("t3_level", 32'(a_lvl), 32'd4);
    chk("t3_ovf", 32'(a_ovf), 32'd0);
    for (int i = 0; i < 4; i++) tick(0, 1, 0);

    // 5: narrow timestamp wraps 15 -> 0 (cycles 47 and 48)
    while (cyc < 47) tick(0, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    chk("t5_ts15", 32'(b_ts), 32'd15);
    tick(0, 1, 0);
    chk("t5_ts0", 32'(b_ts), 32'd0);
    tick(0, 1, 0);

    // 6: count saturation, then async reset with entries held
    do_reset();
    for (int i = 0; i < 9; i++) tick(1, 1, 0);
    chk("t6_b_sat", 32'(b_cnt), 32'd7);
    chk("t6_a_cnt", 32'(a_cnt), 32'd9);
    tick(1, 0, 0);
    chk("t6_level2", 32'(a_lvl), 32'd2);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_async_lvl", 32'(a_lvl), 32'd0);
    chk("t6_async_vld", 32'(a_valid), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(1, 0, 0);
    chk("t6_first_ts", 32'(a_ts), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
